// File: rtl/dpe_demultiplexer.sv
`default_nettype none
// ============================================================================
//  Module      : dpe_demultiplexer
//  Description : AXI-stream 1-to-5 packet demultiplexer. The destination is
//                taken from tuser[2:0] of the first beat and held for the
//                whole packet. Destinations 5..7 are swallowed and counted.
//                Forwarded beats pass through a single shared output
//                register, so latency is one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module dpe_demultiplexer #(
    parameter int TDATA_WIDTH = 128,
    parameter int TUSER_WIDTH = 5,
    // The output port list below is written out for exactly five streams.
    parameter int NUM_OUT     = 5
) (
    input  logic                     clk,
    input  logic                     rst,          // active-low, async assert
    input  logic                     pause,
    output logic                     is_idle,
    output logic [15:0]              drop_cnt,

    // Input stream
    input  logic [TDATA_WIDTH-1:0]   inp_tdata,
    input  logic [TDATA_WIDTH/8-1:0] inp_tkeep,
    input  logic [TUSER_WIDTH-1:0]   inp_tuser,
    input  logic                     inp_tlast,
    input  logic                     inp_tvalid,
    output logic                     inp_tready,

    // Output stream 0
    output logic [TDATA_WIDTH-1:0]   outp0_tdata,
    output logic [TDATA_WIDTH/8-1:0] outp0_tkeep,
    output logic [TUSER_WIDTH-1:0]   outp0_tuser,
    output logic                     outp0_tlast,
    output logic                     outp0_tvalid,
    input  logic                     outp0_tready,

    // Output stream 1
    output logic [TDATA_WIDTH-1:0]   outp1_tdata,
    output logic [TDATA_WIDTH/8-1:0] outp1_tkeep,
    output logic [TUSER_WIDTH-1:0]   outp1_tuser,
    output logic                     outp1_tlast,
    output logic                     outp1_tvalid,
    input  logic                     outp1_tready,

    // Output stream 2
    output logic [TDATA_WIDTH-1:0]   outp2_tdata,
    output logic [TDATA_WIDTH/8-1:0] outp2_tkeep,
    output logic [TUSER_WIDTH-1:0]   outp2_tuser,
    output logic                     outp2_tlast,
    output logic                     outp2_tvalid,
    input  logic                     outp2_tready,

    // Output stream 3
    output logic [TDATA_WIDTH-1:0]   outp3_tdata,
    output logic [TDATA_WIDTH/8-1:0] outp3_tkeep,
    output logic [TUSER_WIDTH-1:0]   outp3_tuser,
    output logic                     outp3_tlast,
    output logic                     outp3_tvalid,
    input  logic                     outp3_tready,

    // Output stream 4
    output logic [TDATA_WIDTH-1:0]   outp4_tdata,
    output logic [TDATA_WIDTH/8-1:0] outp4_tkeep,
    output logic [TUSER_WIDTH-1:0]   outp4_tuser,
    output logic                     outp4_tlast,
    output logic                     outp4_tvalid,
    input  logic                     outp4_tready
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;   // waiting for a first beat
    localparam logic [1:0] c_st_fwd  = 2'd1;   // forwarding to latched dest
    localparam logic [1:0] c_st_drop = 2'd2;   // discarding the packet

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]               r_state;
    logic [2:0]               r_dest;          // destination of packet in flight
    logic                     r_started;       // low until first edge out of reset
    logic                     r_out_valid;
    logic [2:0]               r_out_dest;      // destination of the held beat
    logic [TDATA_WIDTH-1:0]   r_out_tdata;
    logic [TDATA_WIDTH/8-1:0] r_out_tkeep;
    logic [TUSER_WIDTH-1:0]   r_out_tuser;
    logic                     r_out_tlast;
    logic [15:0]              r_drop_cnt;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [2:0]         w_in_dest;
    logic               w_in_dest_ok;
    logic [NUM_OUT-1:0] w_out_tready;
    logic [NUM_OUT-1:0] w_out_tvalid;
    logic               w_sel_ready;
    logic               w_reg_free;
    logic               w_is_drop;
    logic               w_tready;
    logic               w_accept;
    logic               w_fwd_load;
    logic               w_first_drop;

    assign w_in_dest    = inp_tuser[2:0];
    assign w_in_dest_ok = (w_in_dest < 3'(NUM_OUT));

    assign w_out_tready = {outp4_tready, outp3_tready, outp2_tready,
                           outp1_tready, outp0_tready};

    // Ready of the output that currently owns the held beat
    always_comb begin
        w_sel_ready = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (r_out_dest == 3'(i)) begin
                w_sel_ready = w_out_tready[i];
            end
        end
    end

    // The register can take a new beat when empty or draining this cycle.
    // Using the held beat's own destination keeps a new packet to another
    // output from overwriting a beat that is still stalled.
    assign w_reg_free = !r_out_valid || w_sel_ready;

    // Classify the current beat: first beats by their tuser, others by state
    always_comb begin
        w_is_drop = 1'b0;
        case (r_state)
            c_st_idle: w_is_drop = !w_in_dest_ok;
            c_st_drop: w_is_drop = 1'b1;
            default:   w_is_drop = 1'b0;
        endcase
    end

    // Input ready: pause only gates new packets; dropped beats always sink
    always_comb begin
        w_tready = 1'b0;
        if (r_started) begin
            case (r_state)
                c_st_idle: begin
                    if (!pause) begin
                        w_tready = w_in_dest_ok ? w_reg_free : 1'b1;
                    end
                end
                c_st_fwd:  w_tready = w_reg_free;
                c_st_drop: w_tready = 1'b1;
                default:   w_tready = 1'b0;
            endcase
        end
    end

    assign inp_tready   = w_tready;
    assign w_accept     = inp_tvalid && w_tready;
    assign w_fwd_load   = w_accept && !w_is_drop;
    assign w_first_drop = w_accept && (r_state == c_st_idle) && !w_in_dest_ok;

    // Release the input only on the first clock edge after reset deasserts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // Packet FSM: latch the destination on the first beat, return on tlast
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_idle;
            r_dest  <= 3'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_accept && !inp_tlast) begin
                        r_dest  <= w_in_dest;
                        r_state <= w_in_dest_ok ? c_st_fwd : c_st_drop;
                    end
                end
                c_st_fwd, c_st_drop: begin
                    if (w_accept && inp_tlast) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Output register: load on a forwarded beat, empty when drained
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_dest  <= 3'd0;
            r_out_tdata <= '0;
            r_out_tkeep <= '0;
            r_out_tuser <= '0;
            r_out_tlast <= 1'b0;
        end else if (w_fwd_load) begin
            r_out_valid <= 1'b1;
            r_out_dest  <= (r_state == c_st_idle) ? w_in_dest : r_dest;
            r_out_tdata <= inp_tdata;
            r_out_tkeep <= inp_tkeep;
            r_out_tuser <= inp_tuser;
            r_out_tlast <= inp_tlast;
        end else if (r_out_valid && w_sel_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating count of dropped packets, bumped on their first beat
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= 16'd0;
        end else if (w_first_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign is_idle  = (r_state == c_st_idle) && !r_out_valid;

    // ------------------------------------------------------------------------
    // Per-output valid decode: only the held beat's destination is valid
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_out_valid
        assign w_out_tvalid[i] = r_out_valid && (r_out_dest == 3'(i));
    end

    assign outp0_tvalid = w_out_tvalid[0];
    assign outp1_tvalid = w_out_tvalid[1];
    assign outp2_tvalid = w_out_tvalid[2];
    assign outp3_tvalid = w_out_tvalid[3];
    assign outp4_tvalid = w_out_tvalid[4];

    // Payload is shared; qualification is by tvalid alone
    assign outp0_tdata = r_out_tdata;
    assign outp0_tkeep = r_out_tkeep;
    assign outp0_tuser = r_out_tuser;
    assign outp0_tlast = r_out_tlast;

    assign outp1_tdata = r_out_tdata;
    assign outp1_tkeep = r_out_tkeep;
    assign outp1_tuser = r_out_tuser;
    assign outp1_tlast = r_out_tlast;

    assign outp2_tdata = r_out_tdata;
    assign outp2_tkeep = r_out_tkeep;
    assign outp2_tuser = r_out_tuser;
    assign outp2_tlast = r_out_tlast;

    assign outp3_tdata = r_out_tdata;
    assign outp3_tkeep = r_out_tkeep;
    assign outp3_tuser = r_out_tuser;
    assign outp3_tlast = r_out_tlast;

    assign outp4_tdata = r_out_tdata;
    assign outp4_tkeep = r_out_tkeep;
    assign outp4_tuser = r_out_tuser;
    assign outp4_tlast = r_out_tlast;

endmodule
`default_nettype wire

// File: tb/tb_dpe_demultiplexer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dpe_demultiplexer
//  Description : Directed self-checking bench for dpe_demultiplexer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dpe_demultiplexer;

    localparam int DW = 128;
    localparam int UW = 5;
    localparam int KW = DW / 8;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic pause = 1'b0;
    logic        is_idle;
    logic [15:0] drop_cnt;

    logic [DW-1:0] inp_tdata  = '0;
    logic [KW-1:0] inp_tkeep  = '0;
    logic [UW-1:0] inp_tuser  = '0;
    logic          inp_tlast  = 1'b0;
    logic          inp_tvalid = 1'b0;
    logic          inp_tready;

    logic [DW-1:0] o_tdata [5];
    logic [KW-1:0] o_tkeep [5];
    logic [UW-1:0] o_tuser [5];
    logic [4:0]    o_tlast;
    logic [4:0]    ov;
    logic [4:0]    ordy = 5'b11111;

    always #5 clk = ~clk;

    dpe_demultiplexer #(.TDATA_WIDTH(DW), .TUSER_WIDTH(UW), .NUM_OUT(5)) dut (
        .clk(clk), .rst(rst), .pause(pause), .is_idle(is_idle), .drop_cnt(drop_cnt),
        .inp_tdata(inp_tdata), .inp_tkeep(inp_tkeep), .inp_tuser(inp_tuser),
        .inp_tlast(inp_tlast), .inp_tvalid(inp_tvalid), .inp_tready(inp_tready),
        .outp0_tdata(o_tdata[0]), .outp0_tkeep(o_tkeep[0]), .outp0_tuser(o_tuser[0]),
        .outp0_tlast(o_tlast[0]), .outp0_tvalid(ov[0]), .outp0_tready(ordy[0]),
        .outp1_tdata(o_tdata[1]), .outp1_tkeep(o_tkeep[1]), .outp1_tuser(o_tuser[1]),
        .outp1_tlast(o_tlast[1]), .outp1_tvalid(ov[1]), .outp1_tready(ordy[1]),
        .outp2_tdata(o_tdata[2]), .outp2_tkeep(o_tkeep[2]), .outp2_tuser(o_tuser[2]),
        .outp2_tlast(o_tlast[2]), .outp2_tvalid(ov[2]), .outp2_tready(ordy[2]),
        .outp3_tdata(o_tdata[3]), .outp3_tkeep(o_tkeep[3]), .outp3_tuser(o_tuser[3]),
        .outp3_tlast(o_tlast[3]), .outp3_tvalid(ov[3]), .outp3_tready(ordy[3]),
        .outp4_tdata(o_tdata[4]), .outp4_tkeep(o_tkeep[4]), .outp4_tuser(o_tuser[4]),
        .outp4_tlast(o_tlast[4]), .outp4_tvalid(ov[4]), .outp4_tready(ordy[4])
    );

    int n_total = 0;
    int n_bad   = 0;
    int multi_err = 0;
    int stall_err = 0;

    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];

    // Reference model of packet routing
    logic        m_first = 1'b1;
    logic [2:0]  m_dest  = 3'd0;
    logic [15:0] m_drop  = 16'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [2:0] dst, input logic [4:0] u,
                                       input logic l, input logic [15:0] k,
                                       input logic [31:0] d);
        return {7'd0, dst, u, l, k, d};
    endfunction

    function automatic logic [15:0] keep_of(input logic [31:0] d);
        return {d[7:0], ~d[7:0]};
    endfunction

    // Output monitor: collects accepted beats, flags multi-valid and
    // payload changes while a beat is stalled
    logic [4:0]  hold = '0;
    logic [63:0] hold_pk [5];

    always @(negedge clk) begin
        logic [63:0] cur;
        if ($countones(ov) > 1) multi_err++;
        for (int n = 0; n < 5; n++) begin
            cur = pk(3'(n), o_tuser[n], o_tlast[n], o_tkeep[n], o_tdata[n][31:0]);
            if (rst && hold[n] && (!ov[n] || cur !== hold_pk[n])) stall_err++;
            hold[n]    = rst && ov[n] && !ordy[n];
            hold_pk[n] = cur;
            if (ov[n] && ordy[n]) got_q.push_back(cur);
        end
    end

    // Present one beat and wait (bounded) for its handshake; returns at posedge+1
    task automatic send_beat(input logic [31:0] d, input logic [4:0] u,
                             input logic l, output int waits);
        inp_tdata  = DW'(d);
        inp_tkeep  = KW'(keep_of(d));
        inp_tuser  = u;
        inp_tlast  = l;
        inp_tvalid = 1'b1;
        waits = 0;
        #1;
        while (!inp_tready && waits < 50) begin
            @(posedge clk); #1;
            waits++;
        end
        if (!inp_tready) begin
            check("hs_timeout", 64'(inp_tready), 64'd1);
        end else begin
            @(posedge clk);
            if (m_first) begin
                m_dest = u[2:0];
                if (u[2:0] >= 3'd5 && m_drop != 16'hFFFF) m_drop++;
            end
            if (m_dest < 3'd5) exp_q.push_back(pk(m_dest, u, l, keep_of(d), d));
            m_first = l;
            #1;
        end
        inp_tvalid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_q(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [4:0] dl [6];
        dl = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd7};

        // ---------------- reset state ----------------
        inp_tvalid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tready",  64'(inp_tready), 64'd0);
        check("rst_is_idle", 64'(is_idle),    64'd1);
        check("rst_drop",    64'(drop_cnt),   64'd0);
        check("rst_tvalid",  64'(ov),         64'd0);
        check("rst_data",    o_tdata[2][63:0], 64'd0);
        rst = 1'b1;
        #1;
        check("rel_tready_low", 64'(inp_tready), 64'd0);
        inp_tvalid = 1'b0;
        @(posedge clk); #1;
        check("rel_tready_high", 64'(inp_tready), 64'd1);

        // ---------------- 4-beat packet to outp2 ----------------
        for (int i = 0; i < 4; i++) begin
            send_beat(32'h29 + 32'(i), (i == 0) ? 5'd2 : 5'(i + 4), (i == 3), w);
            check($sformatf("t1_wait%0d", i), 64'(w), 64'd0);
            if (i == 0) begin
                check("t1_lat_valid", 64'(ov), 64'b00100);
                check("t1_lat_data",  o_tdata[2][63:0], 64'h29);
                check("t1_busy",      64'(is_idle), 64'd0);
            end
        end
        cycles(2);
        cmp_q("t1");

        // ---------------- dropped packet, then outp0 ----------------
        send_beat(32'h40, 5'd6, 1'b0, w);
        check("t2_wait0", 64'(w), 64'd0);
        check("t2_drop1", 64'(drop_cnt), 64'd1);
        send_beat(32'h41, 5'd0, 1'b0, w);
        check("t2_wait1", 64'(w), 64'd0);
        send_beat(32'h42, 5'd6, 1'b1, w);
        check("t2_wait2", 64'(w), 64'd0);
        check("t2_no_valid", 64'(ov), 64'd0);
        send_beat(32'h50, 5'd0, 1'b0, w);
        send_beat(32'h51, 5'd0, 1'b1, w);
        cycles(2);
        check("t2_drop_end", 64'(drop_cnt), 64'd1);
        cmp_q("t2");

        // ---------------- 5-beat packet to outp1 with stall ----------------
        send_beat(32'h60, 5'd1, 1'b0, w);
        send_beat(32'h61, 5'd1, 1'b0, w);
        ordy[1]    = 1'b0;
        inp_tdata  = DW'(32'h62);
        inp_tkeep  = KW'(keep_of(32'h62));
        inp_tuser  = 5'd1;
        inp_tlast  = 1'b0;
        inp_tvalid = 1'b1;
        #1;
        check("t3_stall_tready0", 64'(inp_tready), 64'd0);
        check("t3_stall_data0",   o_tdata[1][63:0], 64'h61);
        @(posedge clk); #1;
        check("t3_stall_tready1", 64'(inp_tready), 64'd0);
        check("t3_stall_data1",   o_tdata[1][63:0], 64'h61);
        check("t3_stall_valid",   64'(ov), 64'b00010);
        @(posedge clk); #1;
        ordy[1] = 1'b1;
        send_beat(32'h62, 5'd1, 1'b0, w);
        send_beat(32'h63, 5'd1, 1'b0, w);
        send_beat(32'h64, 5'd1, 1'b1, w);
        cycles(2);
        cmp_q("t3");

        // ---------------- pause during 6-beat packet to outp4 ----------------
        send_beat(32'h70, 5'd4, 1'b0, w);
        pause = 1'b1;
        for (int i = 1; i < 6; i++) begin
            send_beat(32'h70 + 32'(i), 5'd4, (i == 5), w);
            check($sformatf("t4_wait%0d", i), 64'(w), 64'd0);
        end
        inp_tdata  = DW'(32'h7F);
        inp_tuser  = 5'd0;
        inp_tlast  = 1'b1;
        inp_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t4_paused%0d", i), 64'(inp_tready), 64'd0);
            @(posedge clk); #1;
        end
        pause = 1'b0;
        send_beat(32'h7F, 5'd0, 1'b1, w);
        cycles(2);
        cmp_q("t4");

        // ---------------- reset mid-packet to outp3 ----------------
        send_beat(32'h80, 5'd3, 1'b0, w);
        send_beat(32'h81, 5'd3, 1'b0, w);
        send_beat(32'h82, 5'd3, 1'b0, w);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        m_first = 1'b1;
        m_drop  = 16'd0;
        #1;
        check("t5_valid",   64'(ov),         64'd0);
        check("t5_drop",    64'(drop_cnt),   64'd0);
        check("t5_tready",  64'(inp_tready), 64'd0);
        check("t5_is_idle", 64'(is_idle),    64'd1);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        send_beat(32'h90, 5'd1, 1'b1, w);
        check("t5_rel_wait", 64'(w), 64'd1);
        cycles(2);
        cmp_q("t5");

        // ---------------- back-to-back single-beat packets ----------------
        for (int i = 0; i < 6; i++) begin
            send_beat(32'hA0 + 32'(i), dl[i], 1'b1, w);
            check($sformatf("t6_wait%0d", i), 64'(w), 64'd0);
        end
        cycles(2);
        check("t6_drop",    64'(drop_cnt), 64'd1);
        check("t6_is_idle", 64'(is_idle),  64'd1);
        cmp_q("t6");

        check("multi_valid",  64'(multi_err), 64'd0);
        check("stall_stable", 64'(stall_err), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dpe_demultiplexer.md
DPE_DEMULTIPLEXER -- requirements
Module: dpe_demultiplexer

Interface
REQ-001 The block SHALL have parameter TDATA_WIDTH, default 128, giving the tdata width of all streams.
REQ-002 The block SHALL have parameter TUSER_WIDTH, default 5, giving the tuser width of all streams; tuser[2:0] is the destination field.
REQ-003 The block SHALL have parameter NUM_OUT, fixed at 5, giving the number of output streams.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous deassert by the source.
REQ-006 pause  input  1  when 1, no new packet is accepted; a packet in flight completes.
REQ-007 is_idle  output  1  1 when no packet is in flight and the output register is empty.
REQ-008 drop_cnt  output  16  saturating count of dropped packets.
REQ-009 inp  dpe_if slave  TDATA_WIDTH/TDATA_WIDTH/8/TUSER_WIDTH  AXI-stream input with tdata, tkeep, tuser, tlast, tvalid and tready.
REQ-010 outp0..outp4  dpe_if master  same widths  AXI-stream outputs, one per destination.

Function
REQ-011 The destination SHALL be sampled from inp.tuser[2:0] on the first beat of each packet only, and held until the beat carrying tlast is accepted.
REQ-012 FSM states: IDLE (awaiting first beat), FWD (forwarding to latched dest), DROP (discarding).
- IDLE->FWD: first beat accepted with dest 0..4, and tlast=0.
- IDLE->DROP: first beat with dest 5..7, and tlast=0.
- FWD/DROP->IDLE: tlast beat accepted.
- A single-beat packet (tlast on the first beat) SHALL stay in IDLE.
REQ-013 In IDLE with pause=1, inp.tready SHALL be 0; pause SHALL be ignored in FWD and DROP.
REQ-014 Forwarded beats SHALL pass through one output register; latency is 1 cycle from input handshake to outpN.tvalid.
- tdata, tkeep, tuser and tlast SHALL be copied unchanged.
REQ-015 inp.tready (forward path) SHALL equal !reg_valid || outp[dest].tready, giving full throughput under continuous ready.
REQ-016 Only outp[dest].tvalid SHALL be asserted; all other outpN.tvalid SHALL be 0.
- Output register contents SHALL be held stable while tvalid=1 and tready=0.
REQ-017 In DROP, and on a dropped single-beat packet, inp.tready SHALL be 1.
- Dropped beats SHALL never appear on any output.
REQ-018 drop_cnt SHALL increment by 1 when the first beat of a dropped packet is accepted, and saturate at 16'hFFFF.
REQ-019 outpN.tready asserted while that output has no valid data SHALL have no effect.
REQ-020 is_idle SHALL equal (state==IDLE) && !reg_valid, registered-free (combinational from state).

Reset
REQ-021 While rst=0:
- state=IDLE, reg_valid=0, all outpN.tvalid=0, inp.tready=0, drop_cnt=0, is_idle=1.
- Output data registers SHALL be 0.
REQ-022 Reset asserted mid-packet SHALL abort the packet with no partial flush.
- After release, the next accepted beat SHALL be treated as a first beat.
REQ-023 inp.tready SHALL stay 0 until the first rising edge after rst deasserts.

Verification
REQ-024 4-beat packet, tuser=2, data 0x29..0x2C, all outputs ready:
- outp2 shows 4 beats on consecutive cycles, 1 cycle after input, tlast on 0x2C.
- Other outputs stay idle.
REQ-025 Packet with tuser=6, 3 beats:
- inp.tready=1 throughout; no outpN.tvalid; drop_cnt goes 0->1.
- A following tuser=0 packet is forwarded to outp0.
REQ-026 5-beat packet to outp1 with outp1.tready low for 2 cycles mid-packet:
- Held beat stays stable and inp.tready=0 during the stall.
- All 5 beats are delivered in order with no duplication.
REQ-027 pause=1 asserted during beat 2 of a 6-beat packet to outp4:
- All 6 beats are delivered.
- The next packet's first beat is not accepted until pause=0.
REQ-028 rst pulsed low during beat 3 of a packet to outp3:
- All outputs drop tvalid immediately and drop_cnt=0.
- The next beat is routed by its own tuser.
REQ-029 Single-beat packets back-to-back to dest 0,1,2,3,4,7:
- One beat per cycle appears on the matching output.
- drop_cnt ends at 1 and is_idle=1 after the last beat drains.
